stream_demux: RTL and testbench
===============================

Name: stream_demux

Overview:
- 1-to-NUM_CH registered demultiplexer. It is the receive-side counterpart of the team's 2:1/N:1 MUX.
- Takes one valid/ready input stream and routes each beat to one of NUM_CH output channels.
- Routing is either by an explicit per-beat select tag (tagged mode) or by an internal round-robin slot counter (TDM mode).
- Each output channel has a one-entry holding register, so every channel has independent backpressure.

Parameters:
- DW, 8, data width per beat.
- NUM_CH, 4, number of output channels (2..16).
- SEL_W, $clog2(NUM_CH), width of the select/slot fields (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mode  in  1  0 = tagged (route by in_sel), 1 = TDM (route by internal slot counter).
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_sel  in  SEL_W  destination channel; used in tagged mode only.
- in_data  in  DW  input payload.
- out_valid  out  NUM_CH  per-channel holding register full.
- out_ready  in  NUM_CH  per-channel consumer ready.
- out_data  out  NUM_CH*DW  channel i payload in bits [i*DW +: DW].
- tdm_slot  out  SEL_W  current TDM destination channel.
- frame_end  out  1  one-cycle pulse when the TDM beat for channel NUM_CH-1 is accepted.
- err_sel  out  1  sticky flag: tagged beat arrived with in_sel >= NUM_CH.
- clr_err  in  1  synchronous clear of err_sel.

Behaviour:
- Reset (async, rst=1): all full flags 0, so out_valid=0. out_data=0, tdm_slot=0, frame_end=0, err_sel=0. in_ready is combinational and therefore equals 1 during and after reset.
- dest = mode ? tdm_slot : in_sel.
- Legal dest: in_ready = !full[dest] || out_ready[dest]. This is combinational, with no dependence on in_valid.
- Illegal dest (tagged mode, in_sel >= NUM_CH): in_ready=1. The beat is accepted and discarded, and err_sel is set the next cycle.
- Accept when in_valid && in_ready and dest is legal:
  - On the next edge, reg[dest] <= in_data and full[dest] <= 1.
  - Latency is 1 cycle from input to out_valid.
  - Throughput is 1 beat/cycle.
- Drain: when out_valid[i] && out_ready[i] and there is no simultaneous fill of channel i, full[i] <= 0. out_data[i] holds its last value and is don't-care when invalid.
- Simultaneous drain and fill on the same channel: reg takes the new data and full stays 1. There is no bubble and no lost beat.
- Channels not addressed by a beat are untouched. Draining one channel never stalls another.
- TDM slot counter:
  - While mode=0, tdm_slot is held at 0.
  - While mode=1, tdm_slot increments on each accepted beat and wraps from NUM_CH-1 to 0.
  - A stalled beat does not advance the slot.
- frame_end: registered pulse, 1 the cycle after acceptance of the beat with tdm_slot=NUM_CH-1 in TDM mode. It is never asserted in tagged mode.
- Mode switch from 1 to 0 mid-frame: the slot clears to 0 on the next edge and the partial frame is abandoned. Beats already held stay valid.
- err_sel: set by an illegal-tag acceptance. clr_err clears it. If set and clear occur in the same cycle, set wins.
- When NUM_CH is a power of two, illegal tags cannot occur and err_sel stays 0.
- in_data/in_sel are ignored when in_valid=0. out_ready is ignored while out_valid=0.

Decomposition:
- Shared package stream_demux_pkg:
  - mode constants MODE_TAGGED=1'b0, MODE_TDM=1'b1.
  - a function computing SEL_W from NUM_CH.
- Sub-module demux_chan_reg: one-entry holding register with fill, drain, full flag and data. Instantiate NUM_CH times via generate.
- The top level holds the dest/ready logic, slot counter, frame_end and err_sel.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> out_valid=0000, tdm_slot=0, err_sel=0, in_ready=1.
- Tagged routing: send 0xA1 sel=2 with all out_ready=0 -> next cycle out_valid=0100 and out_data[23:16]=0xA1. Second beat sel=2 -> in_ready=0 until out_ready[2]=1. Beat sel=1 still accepted meanwhile.
- Back-to-back same channel: out_ready[0]=1 held, stream 0x10,0x11,0x12 to sel=0 -> out_valid[0]=1 on three consecutive cycles with data 0x10,0x11,0x12 and no stall.
- TDM frame: mode=1, all out_ready=1, send 0x20..0x27 -> channels get 20,21,22,23 then 24..27. frame_end pulses after 0x23 and after 0x27. Stall in_valid for 3 cycles mid-frame -> slot unchanged.
- TDM backpressure and mode switch:
  - out_ready[1]=0 with ch1 full: the slot-1 beat is stalled, in_ready=0, slot stays 1.
  - Then set mode=0: slot returns to 0 and ch1 data is still held.
- Illegal tag (NUM_CH=3 build): sel=3 beat accepted, out_valid unchanged, err_sel=1 next cycle. clr_err=1 -> err_sel=0. Set and clear together -> err_sel=1.
- Async reset mid-traffic: assert rst between clock edges with two channels full -> out_valid=0 and tdm_slot=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared definitions for the stream demultiplexer.
//   MODE_TAGGED / MODE_TDM : values of the mode input
//   calc_sel_w()           : width of a channel index for a given channel count
package stream_demux_pkg;

    localparam logic MODE_TAGGED = 1'b0;
    localparam logic MODE_TDM    = 1'b1;

    // A single channel still needs a 1-bit index, hence the floor of 1.
    function automatic int unsigned calc_sel_w(input int unsigned num_ch);
        return (num_ch <= 2) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/demux_chan_reg.sv
// One-entry holding register for a single demux output channel.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   i_fill    : load i_data this cycle (takes priority over drain)
//   i_data    : payload to load
//   i_ready   : consumer ready; empties the register when full and not refilled
//   o_full    : register holds a beat (channel out_valid)
//   o_data    : held payload; keeps its last value after draining
module demux_chan_reg #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_fill,
    input  logic [DW-1:0] i_data,
    input  logic          i_ready,
    output logic          o_full,
    output logic [DW-1:0] o_data
);

    logic          r_full;
    logic [DW-1:0] r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_fill) begin
            // Fill wins over a simultaneous drain, so the channel never bubbles.
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (r_full && i_ready) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;

endmodule

// File: rtl/stream_demux.sv
// 1-to-NUM_CH registered stream demultiplexer.
// Each beat goes to in_sel (tagged mode) or to an internal round-robin slot (TDM mode);
// every channel has its own one-entry holding register and independent backpressure.
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   mode                   : 0 tagged, 1 TDM
//   in_valid/in_ready      : input handshake; in_sel = tagged destination, in_data = payload
//   out_valid/out_ready    : per-channel handshake
//   out_data               : channel i payload at [i*DW +: DW]
//   tdm_slot               : current TDM destination
//   frame_end              : pulse after the beat for the last TDM slot is accepted
//   err_sel / clr_err      : sticky out-of-range tag flag and its synchronous clear
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int unsigned DW     = 8,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned SEL_W  = calc_sel_w(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic [DW-1:0]        in_data,
    output logic [NUM_CH-1:0]    out_valid,
    input  logic [NUM_CH-1:0]    out_ready,
    output logic [NUM_CH*DW-1:0] out_data,
    output logic [SEL_W-1:0]     tdm_slot,
    output logic                 frame_end,
    output logic                 err_sel,
    input  logic                 clr_err
);

    localparam logic [SEL_W:0]   LP_NUM_CH = (SEL_W + 1)'(NUM_CH);
    localparam logic [SEL_W-1:0] LP_LAST   = SEL_W'(NUM_CH - 1);

    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_fill;
    logic [SEL_W-1:0]  w_dest;
    logic              w_legal;
    logic              w_accept;

    logic [SEL_W-1:0]  r_slot;
    logic              r_frame_end;
    logic              r_err_sel;

    // Ready depends only on the destination's state, never on in_valid.
    // Out-of-range tags are always accepted so a bad producer cannot wedge the input.
    always_comb begin
        w_dest   = (mode == MODE_TDM) ? r_slot : in_sel;
        w_legal  = ({1'b0, w_dest} < LP_NUM_CH);
        in_ready = 1'b1;
        if (w_legal) begin
            in_ready = !w_full[w_dest] || out_ready[w_dest];
        end
        w_accept = in_valid && in_ready;
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        assign w_fill[gi] = w_accept && w_legal && (w_dest == SEL_W'(gi));

        demux_chan_reg #(
            .DW (DW)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .i_fill  (w_fill[gi]),
            .i_data  (in_data),
            .i_ready (out_ready[gi]),
            .o_full  (w_full[gi]),
            .o_data  (out_data[gi*DW +: DW])
        );
    end

    // Leaving TDM mode abandons the partial frame: the slot restarts at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot <= '0;
        end else if (mode != MODE_TDM) begin
            r_slot <= '0;
        end else if (w_accept) begin
            r_slot <= (r_slot == LP_LAST) ? '0 : r_slot + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_end <= 1'b0;
        end else begin
            r_frame_end <= (mode == MODE_TDM) && w_accept && (r_slot == LP_LAST);
        end
    end

    // Set has priority over clear so a bad tag in the clearing cycle is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_sel <= 1'b0;
        end else if (w_accept && !w_legal) begin
            r_err_sel <= 1'b1;
        end else if (clr_err) begin
            r_err_sel <= 1'b0;
        end
    end

    assign out_valid = w_full;
    assign tdm_slot  = r_slot;
    assign frame_end = r_frame_end;
    assign err_sel   = r_err_sel;

endmodule

// File: tb/tb_stream_demux.sv
module tb_stream_demux;

    logic       clk;
    logic       rst;
    logic       mode;
    logic       in_valid;
    logic [1:0] in_sel;
    logic [7:0] in_data;
    logic [3:0] out_ready;
    logic       clr_err;

    logic        rdy4, rdy3, fe4, fe3, err4, err3;
    logic [3:0]  ov4;
    logic [2:0]  ov3;
    logic [31:0] od4;
    logic [23:0] od3;
    logic [1:0]  slot4, slot3;

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural model: index 0 = 4-channel build, index 1 = 3-channel build.
    bit       m_full [2][4];
    bit [7:0] m_data [2][4];
    int       m_slot [2];
    bit       m_fe   [2];
    bit       m_err  [2];

    stream_demux #(.DW(8), .NUM_CH(4)) u_dut4 (
        .clk (clk), .rst (rst), .mode (mode), .in_valid (in_valid), .in_ready (rdy4),
        .in_sel (in_sel), .in_data (in_data), .out_valid (ov4), .out_ready (out_ready),
        .out_data (od4), .tdm_slot (slot4), .frame_end (fe4), .err_sel (err4),
        .clr_err (clr_err)
    );

    stream_demux #(.DW(8), .NUM_CH(3)) u_dut3 (
        .clk (clk), .rst (rst), .mode (mode), .in_valid (in_valid), .in_ready (rdy3),
        .in_sel (in_sel), .in_data (in_data), .out_valid (ov3), .out_ready (out_ready[2:0]),
        .out_data (od3), .tdm_slot (slot3), .frame_end (fe3), .err_sel (err3),
        .clr_err (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endfunction

    function automatic int nch(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    function automatic bit model_ready(input int k);
        int dest;
        dest = mode ? m_slot[k] : int'(in_sel);
        if (dest >= nch(k)) return 1'b1;
        return !m_full[k][dest] || out_ready[dest];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
                m_full[k][i] = 1'b0;
                m_data[k][i] = 8'h00;
            end
            m_slot[k] = 0;
            m_fe[k]   = 1'b0;
            m_err[k]  = 1'b0;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            logic [3:0]  dov;
            logic [31:0] dod;
            logic        drdy, dfe, derr;
            logic [1:0]  dslot;
            int          n;
            n     = nch(k);
            dov   = (k == 0) ? ov4 : {1'b0, ov3};
            dod   = (k == 0) ? od4 : {8'h00, od3};
            drdy  = (k == 0) ? rdy4 : rdy3;
            dfe   = (k == 0) ? fe4 : fe3;
            derr  = (k == 0) ? err4 : err3;
            dslot = (k == 0) ? slot4 : slot3;
            chk($sformatf("ch%0d in_ready", n), drdy, model_ready(k));
            chk($sformatf("ch%0d tdm_slot", n), dslot, m_slot[k]);
            chk($sformatf("ch%0d frame_end", n), dfe, m_fe[k]);
            chk($sformatf("ch%0d err_sel", n), derr, m_err[k]);
            for (int i = 0; i < n; i++) begin
                chk($sformatf("ch%0d out_valid[%0d]", n, i), dov[i], m_full[k][i]);
                if (m_full[k][i])
                    chk($sformatf("ch%0d out_data[%0d]", n, i), dod[i*8 +: 8], m_data[k][i]);
            end
        end
    endtask

    // One clock: compare at the falling edge, then advance the model at the rising edge.
    task automatic step();
        bit       nf [2][4];
        bit [7:0] nd [2][4];
        int       ns [2];
        bit       nfe[2];
        bit       ne [2];
        @(negedge clk);
        check_all();
        for (int k = 0; k < 2; k++) begin
            int n, dest;
            bit acc;
            n    = nch(k);
            dest = mode ? m_slot[k] : int'(in_sel);
            acc  = in_valid && model_ready(k);
            for (int i = 0; i < 4; i++) begin
                nf[k][i] = m_full[k][i];
                nd[k][i] = m_data[k][i];
                if (acc && dest == i && i < n) begin
                    nf[k][i] = 1'b1;
                    nd[k][i] = in_data;
                end else if (m_full[k][i] && out_ready[i]) begin
                    nf[k][i] = 1'b0;
                end
            end
            if (!mode)    ns[k] = 0;
            else if (acc) ns[k] = (m_slot[k] + 1) % n;
            else          ns[k] = m_slot[k];
            nfe[k] = mode && acc && (m_slot[k] == n - 1);
            if (acc && !mode && dest >= n) ne[k] = 1'b1;
            else if (clr_err)              ne[k] = 1'b0;
            else                           ne[k] = m_err[k];
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 4; i++) begin
                    m_full[k][i] = nf[k][i];
                    m_data[k][i] = nd[k][i];
                end
                m_slot[k] = ns[k];
                m_fe[k]   = nfe[k];
                m_err[k]  = ne[k];
            end
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = 8'h00;
        out_ready = 4'h0; clr_err = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", ov4, 4'b0000);
        chk("reset tdm_slot", slot4, 2'd0);
        chk("reset err_sel", err4, 1'b0);
        chk("reset in_ready", rdy4, 1'b1);
        rst = 1'b0;

        // Tagged routing and per-channel backpressure
        in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA1;
        step();
        chk("tag first out_valid", ov4, 4'b0100);
        chk("tag first data", od4[23:16], 8'hA1);
        in_data = 8'hA2; #1;
        chk("tag ch2 blocked", rdy4, 1'b0);
        step();
        chk("tag stall keeps data", od4[23:16], 8'hA1);
        in_sel = 2'd1; in_data = 8'hB1; #1;
        chk("tag ch1 free", rdy4, 1'b1);
        step();
        chk("tag two full", ov4, 4'b0110);
        out_ready = 4'b0100; in_sel = 2'd2; in_data = 8'hA2; #1;
        chk("tag drain+fill ready", rdy4, 1'b1);
        step();
        chk("tag drain+fill valid", ov4, 4'b0110);
        chk("tag drain+fill data", od4[23:16], 8'hA2);
        in_valid = 1'b0; out_ready = 4'hF;
        step();
        chk("tag drained", ov4, 4'b0000);

        // Back-to-back beats to one channel
        in_valid = 1'b1; in_sel = 2'd0;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'(8'h10 + i); #1;
            chk("b2b ready", rdy4, 1'b1);
            step();
            chk("b2b valid", ov4[0], 1'b1);
            chk("b2b data", od4[7:0], 8'(8'h10 + i));
        end
        in_valid = 1'b0;
        step();

        // TDM frames with a mid-frame gap
        mode = 1'b1; in_valid = 1'b1;
        for (int j = 0; j < 8; j++) begin
            in_data = 8'(8'h20 + j);
            step();
            chk("tdm frame_end", fe4, ((j % 4) == 3));
            chk("tdm data", od4[(j % 4)*8 +: 8], 8'(8'h20 + j));
            if (j == 5) begin
                in_valid = 1'b0;
                repeat (3) step();
                chk("tdm gap slot", slot4, 2'd2);
                in_valid = 1'b1;
            end
        end
        chk("tdm wrap slot", slot4, 2'd0);

        // TDM backpressure, then leave TDM mode mid-frame
        in_valid = 1'b0;
        step();
        out_ready = 4'h0; in_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            in_data = 8'(8'h30 + j);
            step();
        end
        chk("bp all full", ov4, 4'hF);
        out_ready = 4'b0001; in_data = 8'h34;
        step();
        chk("bp slot advanced", slot4, 2'd1);
        chk("bp ch0 data", od4[7:0], 8'h34);
        out_ready = 4'h0; in_data = 8'h35; #1;
        chk("bp slot1 stalled", rdy4, 1'b0);
        step();
        chk("bp slot held", slot4, 2'd1);
        mode = 1'b0; in_valid = 1'b0;
        step();
        chk("switch slot cleared", slot4, 2'd0);
        chk("switch ch1 held", ov4[1], 1'b1);
        chk("switch ch1 data", od4[15:8], 8'h31);

        // Out-of-range tag on the 3-channel build
        out_ready = 4'hF;
        step();
        out_ready = 4'h0; in_valid = 1'b1; in_sel = 2'd3; in_data = 8'h55; #1;
        chk("illegal ready", rdy3, 1'b1);
        step();
        chk("illegal no fill", ov3, 3'b000);
        chk("illegal err set", err3, 1'b1);
        chk("pow2 no err", err4, 1'b0);
        in_valid = 1'b0; clr_err = 1'b1;
        step();
        chk("err cleared", err3, 1'b0);
        in_valid = 1'b1;
        step();
        chk("err set beats clear", err3, 1'b1);
        clr_err = 1'b0;

        // Asynchronous reset between edges with traffic held
        in_sel = 2'd1; in_data = 8'h66;
        step();
        mode = 1'b1; in_data = 8'h77;
        step();
        chk("pre-reset slot", slot4, 2'd1);
        chk("pre-reset valid", ov4, 4'b1011);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async out_valid", ov4, 4'b0000);
        chk("async tdm_slot", slot4, 2'd0);
        chk("async out_valid 3ch", ov3, 3'b000);
        model_reset();
        step();
        rst = 1'b0; mode = 1'b0;

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom % 4) != 0;
            in_sel    = 2'($urandom);
            in_data   = 8'($urandom);
            out_ready = 4'($urandom);
            clr_err   = ($urandom % 16) == 0;
            if (($urandom % 40) == 0) mode = ~mode;
            if (($urandom % 500) == 0) begin
                rst = 1'b1;
                #1;
                model_reset();
            end
            step();
            rst = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
